alu_status_unit: RTL and testbench



---
 rtl/alu_status_unit.sv | 155 +++++++++++++++
 tb/tb_alu_status_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_status_unit.sv
`default_nettype none
// alu_status_unit -- hmc-6502 ALU slice: 8-bit ALU, TH/TL temporaries, status register P, registered result/flags.
// Revision 1.0
module alu_status_unit (
  input  logic       ph2,
  input  logic       reset,
  input  logic [7:0] a_ext,
  input  logic [7:0] b_ext,
  input  logic       th_in_en,
  input  logic       tl_in_en,
  input  logic       th_out_en,
  input  logic       tl_out_en,
  input  logic [7:0] p_in_en,
  input  logic       p_out_en,
  input  logic       p_sel,
  input  logic [3:0] alu_op,
  input  logic       c_temp_en,
  input  logic       carry_sel,
  output logic [7:0] a_bus,
  output logic [7:0] b_bus,
  output logic [7:0] r,
  output logic [7:0] flags,
  output logic [7:0] p,
  output logic [7:0] th,
  output logic [7:0] tl,
  output logic       c_in
);

  localparam logic [3:0] OP_ADC  = 4'd0;
  localparam logic [3:0] OP_SBC  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORA  = 4'd3;
  localparam logic [3:0] OP_EOR  = 4'd4;
  localparam logic [3:0] OP_ASL  = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_DEC  = 4'd10;
  localparam logic [3:0] OP_PASB = 4'd12;
  localparam logic [3:0] OP_BIT  = 4'd13;

  logic [7:0] result_q, result_d;
  logic [7:0] flags_q, flags_d;
  logic [7:0] th_q, tl_q, p_q;
  logic       c_temp_q;

  assign a_bus = a_ext | (th_out_en ? th_q : 8'h00) | (tl_out_en ? tl_q : 8'h00);
  assign b_bus = b_ext | (p_out_en ? p_q : 8'h00);
  assign c_in  = carry_sel ? c_temp_q : p_q[0];

  // Binary adder, nibble-split so the low-nibble carry is available for BCD.
  logic       is_sbc;
  logic [7:0] b_op;
  logic [4:0] sum_lo, sum_hi;
  logic [7:0] bin_res;
  logic       bin_c, bin_v;

  assign is_sbc  = (alu_op == OP_SBC);
  assign b_op    = is_sbc ? ~b_bus : b_bus;
  assign sum_lo  = {1'b0, a_bus[3:0]} + {1'b0, b_op[3:0]} + {4'b0000, c_in};
  assign sum_hi  = {1'b0, a_bus[7:4]} + {1'b0, b_op[7:4]} + {4'b0000, sum_lo[4]};
  assign bin_res = {sum_hi[3:0], sum_lo[3:0]};
  assign bin_c   = sum_hi[4];
  assign bin_v   = (a_bus[7] == b_op[7]) && (bin_res[7] != a_bus[7]);

  logic       dadj_lo, dadj_hi;
  logic [3:0] dadd_lo, dadd_hi;
  logic [4:0] dsum_hi;
  logic [7:0] dadd_res, dsub_res;

  assign dadj_lo  = (sum_lo > 5'd9);
  assign dadd_lo  = sum_lo[3:0] + (dadj_lo ? 4'd6 : 4'd0);
  assign dsum_hi  = {1'b0, a_bus[7:4]} + {1'b0, b_bus[7:4]} + {4'b0000, dadj_lo};
  assign dadj_hi  = (dsum_hi > 5'd9);
  assign dadd_hi  = dsum_hi[3:0] + (dadj_hi ? 4'd6 : 4'd0);
  assign dadd_res = {dadd_hi, dadd_lo};
  // A nibble borrowed when its carry-out is clear; correction wraps as one 8-bit subtract.
  assign dsub_res = bin_res - {(bin_c ? 4'h0 : 4'h6), (sum_lo[4] ? 4'h0 : 4'h6)};

  logic       res_c, res_v, res_n;

  always_comb begin
    result_d = a_bus;
    res_c    = c_in;
    res_v    = 1'b0;
    case (alu_op)
      OP_ADC: begin
        result_d = p_q[3] ? dadd_res : bin_res;
        res_c    = p_q[3] ? dadj_hi : bin_c;
        res_v    = bin_v;
      end
      OP_SBC: begin
        result_d = p_q[3] ? dsub_res : bin_res;
        res_c    = bin_c;
        res_v    = bin_v;
      end
      OP_AND:  result_d = a_bus & b_bus;
      OP_ORA:  result_d = a_bus | b_bus;
      OP_EOR:  result_d = a_bus ^ b_bus;
      OP_ASL: begin
        result_d = {a_bus[6:0], 1'b0};
        res_c    = a_bus[7];
      end
      OP_LSR: begin
        result_d = {1'b0, a_bus[7:1]};
        res_c    = a_bus[0];
      end
      OP_ROL: begin
        result_d = {a_bus[6:0], c_in};
        res_c    = a_bus[7];
      end
      OP_ROR: begin
        result_d = {c_in, a_bus[7:1]};
        res_c    = a_bus[0];
      end
      OP_INC:  result_d = a_bus + 8'd1;
      OP_DEC:  result_d = a_bus - 8'd1;
      OP_PASB: result_d = b_bus;
      OP_BIT: begin
        result_d = a_bus & b_bus;
        res_v    = b_bus[6];
      end
      default: result_d = a_bus;
    endcase
    res_n   = (alu_op == OP_BIT) ? b_bus[7] : result_d[7];
    flags_d = {res_n, res_v, 4'b0000, (result_d == 8'h00), res_c};
  end

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      result_q <= 8'h00;
      flags_q  <= 8'h00;
      th_q     <= 8'h00;
      tl_q     <= 8'h00;
      p_q      <= 8'h00;
      c_temp_q <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      if (th_in_en) th_q <= result_q;
      if (tl_in_en) tl_q <= result_q;
      p_q <= (p_q & ~p_in_en) | (p_in_en & (p_sel ? result_q : flags_q));
      if (c_temp_en) c_temp_q <= flags_q[0];
    end
  end

  assign r     = result_q;
  assign flags = flags_q;
  assign p     = p_q;
  assign th    = th_q;
  assign tl    = tl_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_status_unit.sv
`default_nettype none
// tb_alu_status_unit -- directed vectors against an arithmetic reference model of alu_status_unit.
// Revision 1.0
module tb_alu_status_unit;

  logic       ph2 = 1'b0;
  logic       reset;
  logic [7:0] a_ext, b_ext, p_in_en;
  logic       th_in_en, tl_in_en, th_out_en, tl_out_en, p_out_en, p_sel, c_temp_en, carry_sel;
  logic [3:0] alu_op;
  logic [7:0] a_bus, b_bus, r, flags, p, th, tl;
  logic       c_in;

  int total = 0;
  int bad   = 0;

  alu_status_unit dut (
    .ph2(ph2), .reset(reset), .a_ext(a_ext), .b_ext(b_ext),
    .th_in_en(th_in_en), .tl_in_en(tl_in_en), .th_out_en(th_out_en), .tl_out_en(tl_out_en),
    .p_in_en(p_in_en), .p_out_en(p_out_en), .p_sel(p_sel), .alu_op(alu_op),
    .c_temp_en(c_temp_en), .carry_sel(carry_sel),
    .a_bus(a_bus), .b_bus(b_bus), .r(r), .flags(flags), .p(p), .th(th), .tl(tl), .c_in(c_in)
  );

  always #5 ph2 = ~ph2;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs from the arithmetic definition of each operation.
  function automatic logic [15:0] alu_ref(input int op, input int a, input int b, input int ci, input int dec);
    int res, c, v, n, t, sa, sb, s, lo, hi, lob;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = ci; v = 0; res = a;
    case (op)
      0: begin
        t = a + b + ci; res = t & 255; c = (t > 255) ? 1 : 0;
        s = sa + sb + ci; v = (s > 127 || s < -128) ? 1 : 0;
        if (dec != 0) begin
          lo = (a & 15) + (b & 15) + ci; if (lo > 9) lo += 6;
          hi = (a >> 4) + (b >> 4) + ((lo > 15) ? 1 : 0); if (hi > 9) hi += 6;
          res = ((hi & 15) << 4) | (lo & 15); c = (hi > 15) ? 1 : 0;
        end
      end
      1: begin
        t = a - b - (1 - ci); res = t & 255; c = (t >= 0) ? 1 : 0;
        s = sa - sb - (1 - ci); v = (s > 127 || s < -128) ? 1 : 0;
        if (dec != 0) begin
          lob = (((a & 15) - (b & 15) - (1 - ci)) < 0) ? 1 : 0;
          res = (res - ((lob != 0) ? 6 : 0) - ((c != 0) ? 0 : 96)) & 255;
        end
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a << 1) & 255; c = a >> 7; end
      6: begin res = a >> 1; c = a & 1; end
      7: begin res = ((a << 1) | ci) & 255; c = a >> 7; end
      8: begin res = (ci << 7) | (a >> 1); c = a & 1; end
      9: res = (a + 1) & 255;
      10: res = (a + 255) & 255;
      12: res = b;
      13: begin res = a & b; v = (b >> 6) & 1; end
      default: res = a;
    endcase
    n = (op == 13) ? (b >> 7) : (res >> 7);
    alu_ref = {n[0], v[0], 4'b0000, (res == 0), c[0], res[7:0]};
  endfunction

  logic [7:0] m_r = 8'h00, m_flags = 8'h00, m_th = 8'h00, m_tl = 8'h00, m_p = 8'h00;
  logic       m_ct = 1'b0;

  function automatic logic [7:0] m_abus();
    return a_ext | (th_out_en ? m_th : 8'h00) | (tl_out_en ? m_tl : 8'h00);
  endfunction
  function automatic logic [7:0] m_bbus();
    return b_ext | (p_out_en ? m_p : 8'h00);
  endfunction
  function automatic logic m_cin();
    return carry_sel ? m_ct : m_p[0];
  endfunction

  always @(posedge ph2 or negedge reset) begin
    logic [15:0] nx;
    if (!reset) begin
      m_r = 0; m_flags = 0; m_th = 0; m_tl = 0; m_p = 0; m_ct = 0;
    end else begin
      nx = alu_ref(int'(alu_op), int'(m_abus()), int'(m_bbus()), int'(m_cin()), int'(m_p[3]));
      if (th_in_en) m_th = m_r;
      if (tl_in_en) m_tl = m_r;
      for (int i = 0; i < 8; i++)
        if (p_in_en[i]) m_p[i] = p_sel ? m_r[i] : m_flags[i];
      if (c_temp_en) m_ct = m_flags[0];
      m_r = nx[7:0];
      m_flags = nx[15:8];
    end
  end

  always @(posedge ph2) begin
    #1;
    cmp("r", r, m_r);
    cmp("flags", flags, m_flags);
    cmp("p", p, m_p);
    cmp("th", th, m_th);
    cmp("tl", tl, m_tl);
    cmp("a_bus", a_bus, m_abus());
    cmp("b_bus", b_bus, m_bbus());
    cmp("c_in", {7'b0, c_in}, {7'b0, m_cin()});
  end

  task automatic nxt();
    @(negedge ph2);
    a_ext = 0; b_ext = 0; p_in_en = 0; alu_op = 4'd11;
    th_in_en = 0; tl_in_en = 0; th_out_en = 0; tl_out_en = 0;
    p_out_en = 0; p_sel = 0; c_temp_en = 0; carry_sel = 0;
  endtask

  task automatic cyc();
    @(posedge ph2);
    #2;
  endtask

  int t_op[12] = '{2, 3, 4, 5, 6, 7, 9, 10, 12, 14, 0, 1};
  int t_a [12] = '{8'hF0, 8'h0F, 8'hFF, 8'h41, 8'h81, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'h45, 8'h32};
  int t_b [12] = '{8'h3C, 8'hA0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h38, 8'h17};

  initial begin
    a_ext = 0; b_ext = 0; p_in_en = 0; alu_op = 4'd11;
    th_in_en = 0; tl_in_en = 0; th_out_en = 0; tl_out_en = 0;
    p_out_en = 0; p_sel = 0; c_temp_en = 0; carry_sel = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    cmp("rst r", r, 8'h00); cmp("rst flags", flags, 8'h00);
    cmp("rst p", p, 8'h00); cmp("rst th", th, 8'h00); cmp("rst tl", tl, 8'h00);

    nxt(); reset = 1'b1;
    repeat (3) begin nxt(); cyc(); end
    cmp("idle r", r, 8'h00); cmp("idle flags", flags, 8'h02);
    cmp("idle p", p, 8'h00); cmp("idle th", th, 8'h00); cmp("idle tl", tl, 8'h00);

    nxt(); alu_op = 0; a_ext = 8'h50; b_ext = 8'h50; cyc();
    cmp("adc r", r, 8'hA0); cmp("adc flags", flags, 8'hC0);

    nxt(); a_ext = 8'h01; cyc();
    nxt(); p_in_en = 8'h01; p_sel = 1; cyc();
    cmp("p0 set", p, 8'h01);
    nxt(); alu_op = 1; a_ext = 8'h00; b_ext = 8'h01; cyc();
    cmp("sbc r", r, 8'hFF); cmp("sbc flags", flags, 8'h80);

    nxt(); a_ext = 8'h08; cyc();
    nxt(); p_in_en = 8'hFF; p_sel = 1; cyc();
    cmp("p dec", p, 8'h08);
    nxt(); alu_op = 0; a_ext = 8'h19; b_ext = 8'h28; cyc();
    cmp("dadc r", r, 8'h47); cmp("dadc flags", flags, 8'h00);
    nxt(); alu_op = 0; a_ext = 8'h99; b_ext = 8'h01; cyc();
    cmp("dadc wrap r", r, 8'h00); cmp("dadc wrap flags", flags, 8'h03);
    nxt(); c_temp_en = 1; cyc();
    nxt(); alu_op = 1; carry_sel = 1; a_ext = 8'h50; b_ext = 8'h01;
    #1 cmp("c_in ctemp", {7'b0, c_in}, 8'h01);
    cyc();
    cmp("dsbc r", r, 8'h49); cmp("dsbc flags", flags, 8'h01);

    nxt(); cyc();
    nxt(); p_in_en = 8'hFF; p_sel = 1; cyc();
    cmp("p clr", p, 8'h00);

    nxt(); a_ext = 8'h3C; cyc();
    nxt(); th_in_en = 1; a_ext = 8'h03; cyc();
    cmp("th load", th, 8'h3C);
    nxt(); th_out_en = 1; tl_in_en = 1; cyc();
    cmp("abus th", a_bus, 8'h3C); cmp("tl load", tl, 8'h03);
    nxt(); th_out_en = 1; tl_out_en = 1; cyc();
    cmp("abus th|tl", a_bus, 8'h3F);
    nxt(); tl_out_en = 1; tl_in_en = 1;
    #1 cmp("abus old tl", a_bus, 8'h03);
    cyc();
    cmp("tl new", tl, 8'h3F); cmp("abus new tl", a_bus, 8'h3F);

    nxt(); alu_op = 13; b_ext = 8'h80; carry_sel = 1; cyc();
    cmp("bit flags", flags, 8'h83); cmp("bit r", r, 8'h00);
    nxt(); p_in_en = 8'h01; p_sel = 0; a_ext = 8'hFF; cyc();
    cmp("p from flags", p, 8'h01);
    nxt(); p_in_en = 8'h08; p_sel = 1; cyc();
    cmp("p from r", p, 8'h09);
    nxt(); p_out_en = 1; b_ext = 8'h40;
    #1 cmp("bbus p", b_bus, 8'h49);
    cyc();

    nxt(); alu_op = 5; a_ext = 8'h80; cyc();
    cmp("asl r", r, 8'h00); cmp("asl flags", flags, 8'h03);
    nxt(); alu_op = 8; a_ext = 8'h01; cyc();
    cmp("ror r", r, 8'h80); cmp("ror flags", flags, 8'h81);

    for (int i = 0; i < 12; i++) begin
      nxt(); alu_op = t_op[i][3:0]; a_ext = t_a[i][7:0]; b_ext = t_b[i][7:0];
      carry_sel = i[0]; cyc();
    end

    repeat (3) begin nxt(); cyc(); end
    cmp("hold th", th, 8'h3C); cmp("hold tl", tl, 8'h3F); cmp("hold p", p, 8'h09);

    nxt(); th_in_en = 1; tl_in_en = 1; p_in_en = 8'hFF; a_ext = 8'h77;
    #2 reset = 1'b0;
    #1;
    cmp("mid rst r", r, 8'h00); cmp("mid rst th", th, 8'h00);
    cmp("mid rst tl", tl, 8'h00); cmp("mid rst p", p, 8'h00);
    @(posedge ph2); #2;
    cmp("rst hold th", th, 8'h00);
    nxt(); reset = 1'b1; cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
